// File: rtl/csr_pkg.sv
// Shared Zicsr definitions for the CSR read-modify-write sequencer:
// funct3 encodings, sequencer states and CSR address field positions.
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    // CSR address fields: [11:10]==2'b11 marks a read-only CSR.
    localparam int unsigned CSR_RO_MSB   = 11;
    localparam int unsigned CSR_RO_LSB   = 10;
    localparam int unsigned CSR_PRIV_MSB = 9;
    localparam int unsigned CSR_PRIV_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } csr_state_e;

    function automatic logic f3_reserved(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational operand select and RW/RS/RC merge for Zicsr instructions.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] old,
    output logic [XLEN-1:0] new_val
);

    logic [XLEN-1:0] operand;

    always_comb begin
        operand = funct3[2] ? {{(XLEN-5){1'b0}}, rs1} : rs1_data;
        unique case (funct3[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old | operand;
            2'b11:   new_val = old & ~operand;
            default: new_val = old;
        endcase
    end

endmodule

// File: rtl/csr_rmw_seq.sv
// CSR read-modify-write sequencer: reads a CSR, issues one write strobe, returns the old value.
// Optional access checking (resp_illegal port) is enabled by defining CSR_ACCESS_CHECK_EN.
module csr_rmw_seq
    import csr_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM    = 4096,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_funct3,
    input  logic [4:0]              req_rs1,
    input  logic [XLEN-1:0]         req_rs1_data,
    input  logic [$clog2(NUM)-1:0]  req_addr,
    output logic [$clog2(NUM)-1:0]  csr_addr,
    output logic                    csr_s_csr,
    output logic                    csr_s_csrsc,
    output logic [4:0]              csr_rs1,
    output logic [XLEN-1:0]         csr_data_w,
    input  logic [XLEN-1:0]         csr_data_r,
    output logic                    resp_valid,
    input  logic                    resp_ready,
`ifdef CSR_ACCESS_CHECK_EN
    output logic                    resp_illegal,
`endif
    output logic [XLEN-1:0]         resp_rdata
);

    localparam int unsigned AW = $clog2(NUM);
    localparam int unsigned CW = $clog2(RD_LAT + 1);

    csr_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [AW-1:0]   csr_addr_q, csr_addr_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            s_csr_q, s_csr_d;
    logic            s_csrsc_q, s_csrsc_d;
    logic [4:0]      csr_rs1_q, csr_rs1_d;
    logic [XLEN-1:0] data_w_q, data_w_d;
    logic [XLEN-1:0] new_val;
    logic            skip_write;
    logic [XLEN-1:0] rdata_sel;
    logic            accept;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

    csr_rmw_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3  (f3_q),
        .rs1     (rs1_q),
        .rs1_data(rs1_data_q),
        .old     (csr_data_r),
        .new_val (new_val)
    );

`ifdef CSR_ACCESS_CHECK_EN
    logic illegal_q, illegal_d;
    logic req_illegal;

    // Read-only CSRs may still be read by set/clear forms with rs1==0.
    assign req_illegal = f3_reserved(req_funct3) ||
                         ((req_addr[CSR_RO_MSB:CSR_RO_LSB] == 2'b11) &&
                          ((req_funct3[1:0] == 2'b01) || (req_rs1 != 5'd0)));
    assign skip_write   = illegal_q;
    assign rdata_sel    = illegal_q ? '0 : csr_data_r;
    assign resp_illegal = illegal_q;

    always_comb begin
        illegal_d = illegal_q;
        if (accept) begin
            illegal_d = req_illegal;
        end else if (state_q == RESP && resp_ready) begin
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign skip_write = f3_reserved(f3_q);
    assign rdata_sel  = csr_data_r;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        rs1_d        = rs1_q;
        rs1_data_d   = rs1_data_q;
        csr_addr_d   = csr_addr_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        s_csr_d      = s_csr_q;
        s_csrsc_d    = s_csrsc_q;
        csr_rs1_d    = csr_rs1_q;
        data_w_d     = data_w_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d        = req_funct3;
                    rs1_d       = req_rs1;
                    rs1_data_d  = req_rs1_data;
                    csr_addr_d  = req_addr;
                    cnt_d       = CW'(RD_LAT);
                    req_ready_d = 1'b0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    resp_rdata_d = rdata_sel;
                    if (skip_write) begin
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        s_csr_d   = 1'b1;
                        s_csrsc_d = f3_q[1];
                        csr_rs1_d = rs1_q;
                        data_w_d  = new_val;
                        state_d   = WRITE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WRITE: begin
                s_csr_d      = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            rs1_q        <= '0;
            rs1_data_q   <= '0;
            csr_addr_q   <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            s_csr_q      <= 1'b0;
            s_csrsc_q    <= 1'b0;
            csr_rs1_q    <= '0;
            data_w_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            rs1_q        <= rs1_d;
            rs1_data_q   <= rs1_data_d;
            csr_addr_q   <= csr_addr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            s_csr_q      <= s_csr_d;
            s_csrsc_q    <= s_csrsc_d;
            csr_rs1_q    <= csr_rs1_d;
            data_w_q     <= data_w_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign csr_addr    = csr_addr_q;
    assign csr_s_csr   = s_csr_q;
    assign csr_s_csrsc = s_csrsc_q;
    assign csr_rs1     = csr_rs1_q;
    assign csr_data_w  = data_w_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;

endmodule
